// File: rtl/riscv_pkg.sv
// Shared RV32 decode encodings: opcodes, ALU/immediate/result selects and the
// bundle of control bits carried across the D->E boundary.
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MEXT = 7'b0000001;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0, ALU_SUB  = 4'h1, ALU_AND  = 4'h2, ALU_OR   = 4'h3,
      ALU_XOR  = 4'h4, ALU_SLT  = 4'h5, ALU_SLTU = 4'h6, ALU_SLL  = 4'h7,
      ALU_SRL  = 4'h8, ALU_SRA  = 4'h9, ALU_MUL  = 4'hA, ALU_MULH = 4'hB,
      ALU_DIV  = 4'hC, ALU_DIVU = 4'hD, ALU_REM  = 4'hE, ALU_REMU = 4'hF
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4
   } imm_src_t;

   typedef enum logic [1:0] {
      RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC4 = 2'd2
   } res_src_t;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_t;

   typedef struct packed {
      logic     valid;
      logic     illegal;
      logic     reg_write;
      logic     mem_write;
      logic     alu_src;
      logic     branch;
      logic     jump;
      res_src_t result_src;
      alu_op_t  alu_ctrl;
   } ctrl_t;

   // funct3 -> ALU op for the unmodified (funct7 = 0) register/immediate forms
   function automatic alu_op_t base_alu_op(input logic [2:0] funct3);
      case (funct3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic is_mul_op(input alu_op_t op);
      return (op == ALU_MUL) || (op == ALU_MULH);
   endfunction

   function automatic logic is_div_op(input alu_op_t op);
      return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
   endfunction

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// Decode-stage control bundle: instruction/hazard inputs in, registered
// Execute controls and the M-op busy flag out.
interface decode_ctrl_stage_if;
   logic [31:0] InstrD;
   logic        ValidD;
   logic        StallE;
   logic        FlushE;
   logic [2:0]  ImmSrcD;
   logic        RegWriteE;
   logic        MemWriteE;
   logic        ALUSrcE;
   logic        BranchE;
   logic        JumpE;
   logic [1:0]  ResultSrcE;
   logic [3:0]  ALUControlE;
   logic        ValidE;
   logic        IllegalE;
   logic        MdBusy;

   modport master (
      output InstrD, ValidD, StallE, FlushE,
      input  ImmSrcD, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE,
      input  ResultSrcE, ALUControlE, ValidE, IllegalE, MdBusy
   );

   modport slave (
      input  InstrD, ValidD, StallE, FlushE,
      output ImmSrcD, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE,
      output ResultSrcE, ALUControlE, ValidE, IllegalE, MdBusy
   );
endinterface

// File: rtl/instr_decoder.sv
// Combinational RV32I(+M) decoder: instruction word to Execute controls and
// immediate format; illegal encodings come out with every control cleared.
module instr_decoder
   import riscv_pkg::*;
#(
   parameter bit EN_MEXT = 1'b1
) (
   input  logic [31:0] instr,
   output ctrl_t       ctrl,
   output imm_src_t    imm_src
);

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic       illegal;
   ctrl_t      dec;
   logic       unused_fields;

   assign opcode        = instr[6:0];
   assign funct3        = instr[14:12];
   assign funct7        = instr[31:25];
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   always_comb begin
      dec     = '0;
      imm_src = IMM_I;
      illegal = 1'b0;
      case (opcode)
         OP_R: begin
            dec.reg_write = 1'b1;
            case (funct7)
               F7_BASE: dec.alu_ctrl = base_alu_op(funct3);
               F7_ALT: begin
                  if (funct3 == 3'b000)      dec.alu_ctrl = ALU_SUB;
                  else if (funct3 == 3'b101) dec.alu_ctrl = ALU_SRA;
                  else                       illegal = 1'b1;
               end
               F7_MEXT: begin
                  if (!EN_MEXT) begin
                     illegal = 1'b1;
                  end else begin
                     case (funct3)
                        3'b000:  dec.alu_ctrl = ALU_MUL;
                        3'b001:  dec.alu_ctrl = ALU_MULH;
                        3'b100:  dec.alu_ctrl = ALU_DIV;
                        3'b101:  dec.alu_ctrl = ALU_DIVU;
                        3'b110:  dec.alu_ctrl = ALU_REM;
                        3'b111:  dec.alu_ctrl = ALU_REMU;
                        default: illegal = 1'b1;
                     endcase
                  end
               end
               default: illegal = 1'b1;
            endcase
         end
         OP_I: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            // Shift immediates carry a funct7 in imm[11:5]; other forms use it as data
            case (funct3)
               3'b001: begin
                  if (funct7 == F7_BASE) dec.alu_ctrl = ALU_SLL;
                  else                   illegal = 1'b1;
               end
               3'b101: begin
                  if (funct7 == F7_BASE)     dec.alu_ctrl = ALU_SRL;
                  else if (funct7 == F7_ALT) dec.alu_ctrl = ALU_SRA;
                  else                       illegal = 1'b1;
               end
               default: dec.alu_ctrl = base_alu_op(funct3);
            endcase
         end
         OP_LOAD: begin
            dec.reg_write  = 1'b1;
            dec.alu_src    = 1'b1;
            dec.result_src = RES_MEM;
            if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
         end
         OP_STORE: begin
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
            imm_src       = IMM_S;
            if (funct3[2] || funct3 == 3'b011) illegal = 1'b1;
         end
         OP_BRANCH: begin
            dec.branch   = 1'b1;
            dec.alu_ctrl = ALU_SUB;
            imm_src      = IMM_B;
            if (funct3[2:1] == 2'b01) illegal = 1'b1;
         end
         OP_JAL: begin
            dec.jump       = 1'b1;
            dec.reg_write  = 1'b1;
            dec.result_src = RES_PC4;
            imm_src        = IMM_J;
         end
         OP_JALR: begin
            dec.jump       = 1'b1;
            dec.reg_write  = 1'b1;
            dec.result_src = RES_PC4;
            dec.alu_src    = 1'b1;
            if (funct3 != 3'b000) illegal = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
            imm_src       = IMM_U;
         end
         default: illegal = 1'b1;
      endcase

      ctrl = dec;
      if (illegal) begin
         ctrl         = '0;
         ctrl.illegal = 1'b1;
      end
   end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Decode control with the registered D->E control boundary and the multi-cycle
// M-extension sequencer that holds Execute (and stalls F/D) for LAT cycles.
module decode_ctrl_stage
   import riscv_pkg::*;
#(
   parameter bit EN_MEXT = 1'b1,
   parameter int MUL_LAT = 2,
   parameter int DIV_LAT = 33
) (
   input  logic                clk,
   input  logic                rst,
   decode_ctrl_stage_if.slave  bus
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);
   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);
   localparam bit MUL_MC = (MUL_LAT > 1);
   localparam bit DIV_MC = (DIV_LAT > 1);

   ctrl_t     dec_ctrl;
   ctrl_t     cap_ctrl;
   ctrl_t     ctrl_p1;
   imm_src_t  imm_src;
   md_state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic      md_busy;
   logic      capture;
   logic      start_md;

   instr_decoder #(
      .EN_MEXT (EN_MEXT)
   ) u_instr_decoder (
      .instr   (bus.InstrD),
      .ctrl    (dec_ctrl),
      .imm_src (imm_src)
   );

   always_comb begin
      cap_ctrl = '0;
      if (bus.ValidD) begin
         cap_ctrl       = dec_ctrl;
         cap_ctrl.valid = 1'b1;
      end
   end

   assign md_busy  = (state == MD_RUN);
   assign capture  = !bus.FlushE && !bus.StallE && !md_busy;
   // Illegal words decode to ADD, so they can never start the sequencer
   assign start_md = capture && cap_ctrl.valid &&
                     ((is_mul_op(cap_ctrl.alu_ctrl) && MUL_MC) ||
                      (is_div_op(cap_ctrl.alu_ctrl) && DIV_MC));

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         MD_IDLE: begin
            if (start_md) begin
               state_nx = MD_RUN;
               cnt_nx   = is_mul_op(cap_ctrl.alu_ctrl) ? MUL_LOAD : DIV_LOAD;
            end
         end
         MD_RUN: begin
            if (bus.FlushE || cnt == CW'(1)) begin
               state_nx = MD_IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: begin
            state_nx = MD_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // D -> E boundary
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl_p1 <= '0;
         state   <= MD_IDLE;
         cnt     <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (bus.FlushE)   ctrl_p1 <= '0;
         else if (capture) ctrl_p1 <= cap_ctrl;
      end
   end

   assign bus.ImmSrcD     = imm_src;
   assign bus.RegWriteE   = ctrl_p1.reg_write;
   assign bus.MemWriteE   = ctrl_p1.mem_write;
   assign bus.ALUSrcE     = ctrl_p1.alu_src;
   assign bus.BranchE     = ctrl_p1.branch;
   assign bus.JumpE       = ctrl_p1.jump;
   assign bus.ResultSrcE  = ctrl_p1.result_src;
   assign bus.ALUControlE = ctrl_p1.alu_ctrl;
   assign bus.ValidE      = ctrl_p1.valid;
   assign bus.IllegalE    = ctrl_p1.illegal;
   assign bus.MdBusy      = md_busy;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboard bench for decode_ctrl_stage: two instances (M-ext on, M-ext off)
// share one stimulus stream and are each checked against a table-driven model.
module tb_decode_ctrl_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] instr = '0;
   logic        valid = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;

   always #5 clk = ~clk;

   decode_ctrl_stage_if bus_a ();
   decode_ctrl_stage_if bus_b ();

   assign bus_a.InstrD = instr;
   assign bus_a.ValidD = valid;
   assign bus_a.StallE = stall;
   assign bus_a.FlushE = flush;
   assign bus_b.InstrD = instr;
   assign bus_b.ValidD = valid;
   assign bus_b.StallE = stall;
   assign bus_b.FlushE = flush;

   decode_ctrl_stage #(.EN_MEXT(1'b1), .MUL_LAT(2), .DIV_LAT(33)) u_dut_a (
      .clk (clk), .rst (rst), .bus (bus_a)
   );
   decode_ctrl_stage #(.EN_MEXT(1'b0), .MUL_LAT(1), .DIV_LAT(3)) u_dut_b (
      .clk (clk), .rst (rst), .bus (bus_b)
   );

   logic [13:0] out_a, out_b;
   assign out_a = {bus_a.ValidE, bus_a.IllegalE, bus_a.RegWriteE, bus_a.MemWriteE,
                   bus_a.ALUSrcE, bus_a.BranchE, bus_a.JumpE, bus_a.ResultSrcE,
                   bus_a.ALUControlE, bus_a.MdBusy};
   assign out_b = {bus_b.ValidE, bus_b.IllegalE, bus_b.RegWriteE, bus_b.MemWriteE,
                   bus_b.ALUSrcE, bus_b.BranchE, bus_b.JumpE, bus_b.ResultSrcE,
                   bus_b.ALUControlE, bus_b.MdBusy};

   typedef struct packed {
      logic [2:0] imm;
      logic       ill, rw, mw, asrc, br, jmp;
      logic [1:0] res;
      logic [3:0] alu;
   } dec_t;

   typedef struct {
      logic [13:0] a;
      logic [13:0] b;
      logic [2:0]  imm;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   logic [3:0] base_tab [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
   logic [3:0] m_tab    [8] = '{4'hA, 4'hB, 4'h0, 4'h0, 4'hC, 4'hD, 4'hE, 4'hF};

   bit   mext [2] = '{1'b1, 1'b0};
   int   mlat [2] = '{2, 1};
   int   dlat [2] = '{33, 3};
   bit   e_valid [2];
   dec_t e_dec [2];
   int   rem [2];

   localparam logic [31:0] I_ADD  = 32'h003100B3;
   localparam logic [31:0] I_SW   = 32'h0020A223;
   localparam logic [31:0] I_DIV  = 32'h0220C0B3;
   localparam logic [31:0] I_MUL  = 32'h022080B3;
   localparam logic [31:0] I_SRAI = 32'h4010D093;
   localparam logic [31:0] I_LUI  = 32'h123450B7;
   localparam logic [31:0] I_JAL  = 32'h008000EF;
   localparam logic [31:0] I_BAD  = 32'h0000007F;

   function automatic dec_t ref_dec(input logic [31:0] ins, input bit mx);
      dec_t       d;
      logic [6:0] op, f7;
      logic [2:0] f3, im;
      bit         ill;
      d = '0; ill = 1'b0;
      op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
      case (op)
         7'h33: begin
            d.rw = 1'b1;
            if (f7 == 7'h00) d.alu = base_tab[f3];
            else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) d.alu = (f3 == 3'd0) ? 4'd1 : 4'd9;
            else if (f7 == 7'h01 && mx && f3 != 3'd2 && f3 != 3'd3) d.alu = m_tab[f3];
            else ill = 1'b1;
         end
         7'h13: begin
            d.rw = 1'b1; d.asrc = 1'b1;
            if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
            else if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
            else d.alu = (f3 == 3'd5 && f7 == 7'h20) ? 4'd9 : base_tab[f3];
         end
         7'h03: begin d.rw = 1'b1; d.asrc = 1'b1; d.res = 2'd1; ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7); end
         7'h23: begin d.mw = 1'b1; d.asrc = 1'b1; d.imm = 3'd1; ill = (f3 > 3'd2); end
         7'h63: begin d.br = 1'b1; d.alu = 4'd1; d.imm = 3'd2; ill = (f3 == 3'd2 || f3 == 3'd3); end
         7'h6F: begin d.jmp = 1'b1; d.rw = 1'b1; d.res = 2'd2; d.imm = 3'd3; end
         7'h67: begin d.jmp = 1'b1; d.rw = 1'b1; d.res = 2'd2; d.asrc = 1'b1; ill = (f3 != 3'd0); end
         7'h37, 7'h17: begin d.rw = 1'b1; d.asrc = 1'b1; d.imm = 3'd4; end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         im = d.imm; d = '0; d.imm = im; d.ill = 1'b1;
      end
      return d;
   endfunction

   function automatic logic [13:0] exp_vec(input int k);
      return {e_valid[k], e_dec[k].ill, e_dec[k].rw, e_dec[k].mw, e_dec[k].asrc,
              e_dec[k].br, e_dec[k].jmp, e_dec[k].res, e_dec[k].alu, (rem[k] > 0)};
   endfunction

   task automatic reset_model();
      for (int k = 0; k < 2; k++) begin
         e_valid[k] = 1'b0; e_dec[k] = '0; rem[k] = 0;
      end
   endtask

   // One clock edge of the Execute-occupancy rules for instance k
   task automatic step(input int k);
      bit busy;
      int lat;
      if (flush) begin
         e_valid[k] = 1'b0; e_dec[k] = '0; rem[k] = 0;
      end else begin
         busy = (rem[k] > 0);
         if (busy) rem[k]--;
         if (!stall && !busy) begin
            if (valid) begin
               e_valid[k] = 1'b1;
               e_dec[k]   = ref_dec(instr, mext[k]);
               if (!e_dec[k].ill && e_dec[k].alu >= 4'hA) begin
                  lat    = (e_dec[k].alu < 4'hC) ? mlat[k] : dlat[k];
                  rem[k] = lat - 1;
               end
            end else begin
               e_valid[k] = 1'b0; e_dec[k] = '0;
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, want, $time);
      end
   endtask

   task automatic cyc(input logic [31:0] ins, input bit vd, input bit st, input bit fl);
      exp_t e;
      instr = ins; valid = vd; stall = st; flush = fl;
      e.a   = exp_vec(0);
      e.b   = exp_vec(1);
      e.imm = ref_dec(ins, 1'b1).imm;
      q.push_back(e);
      @(posedge clk);
      step(0);
      step(1);
      #1;
   endtask

   task automatic reset_pulse();
      #1 rst = 1'b0;
      #1;
      chk("async_rst_a", {2'b0, out_a}, 16'h0);
      chk("async_rst_b", {2'b0, out_b}, 16'h0);
      reset_model();
      instr = '0; valid = 1'b0; stall = 1'b0; flush = 1'b0;
      @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      int          s;
      r = $urandom;
      s = $urandom_range(0, 10);
      r[6:0] = (s < 9) ? ops[s] : ((s == 9) ? ops[0] : 7'($urandom));
      case ($urandom_range(0, 3))
         0:       r[31:25] = 7'h00;
         1:       r[31:25] = 7'h20;
         2:       r[31:25] = 7'h01;
         default: r[31:25] = 7'($urandom);
      endcase
      return r;
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("e_out_a", {2'b0, out_a}, {2'b0, e.a});
         chk("e_out_b", {2'b0, out_b}, {2'b0, e.b});
         chk("imm_a", {13'b0, bus_a.ImmSrcD}, {13'b0, e.imm});
         chk("imm_b", {13'b0, bus_b.ImmSrcD}, {13'b0, e.imm});
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "bench timeout");
   end

   initial begin : driver
      reset_model();
      instr = I_ADD; valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_a", {2'b0, out_a}, 16'h0);
      chk("reset_b", {2'b0, out_b}, 16'h0);
      instr = '0; valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;

      cyc(I_ADD, 1, 0, 0);  cyc('0, 0, 0, 0);
      cyc(I_SW, 1, 0, 0);   cyc('0, 0, 0, 0);
      cyc(I_SRAI, 1, 0, 0); cyc(I_LUI, 1, 0, 0); cyc(I_JAL, 1, 0, 0); cyc(I_BAD, 1, 0, 0);
      cyc('0, 0, 0, 0);

      cyc(I_DIV, 1, 0, 0);
      repeat (36) cyc(I_ADD, 1, 0, 0);
      cyc('0, 0, 0, 0);

      cyc(I_DIV, 1, 0, 0);
      repeat (34) cyc(I_DIV, 1, 0, 0);
      repeat (35) cyc('0, 0, 0, 0);

      cyc(I_DIV, 1, 0, 0);
      repeat (5) cyc(I_ADD, 1, 1, 0);
      repeat (30) cyc(I_ADD, 1, 0, 0);

      cyc(I_MUL, 1, 0, 0);
      cyc(I_ADD, 1, 0, 1);
      cyc(I_ADD, 1, 0, 0);
      cyc(I_MUL, 1, 0, 0);
      repeat (3) cyc(I_SW, 1, 0, 0);
      cyc('0, 0, 0, 0);

      cyc(I_DIV, 1, 0, 0);
      repeat (5) cyc('0, 0, 0, 0);
      reset_pulse();
      repeat (3) cyc('0, 0, 0, 0);

      for (int i = 0; i < 1500; i++)
         cyc(rand_instr(), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 19) == 0));

      repeat (2) cyc('0, 0, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      chk("queue_drained", 16'(q.size()), 16'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
